// File: rtl/thistle_core_p.sv
// thistle_core_p: parametrised single-accumulator multi-cycle core.
// Internal word-addressed memory with a synchronous read port, an
// auto-incrementing program loader, zero/carry flags with conditional jumps,
// and ready/valid handshaked input and output channels.
module thistle_core_p #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              program_mode,
   input  logic              pm_addr_we,
   input  logic [ADDR_W-1:0] pm_address,
   input  logic              pm_data_we,
   input  logic [DATA_W-1:0] pm_data,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] acc
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_OUTW   = 3'd4;
   localparam logic [2:0] S_INW    = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;
   localparam logic [2:0] S_PROG   = 3'd7;

   localparam logic [3:0] OP_LDA = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_STA = 4'd4;
   localparam logic [3:0] OP_LDI = 4'd5;
   localparam logic [3:0] OP_JMP = 4'd6;
   localparam logic [3:0] OP_JC  = 4'd7;
   localparam logic [3:0] OP_JZ  = 4'd8;
   localparam logic [3:0] OP_OUT = 4'd9;
   localparam logic [3:0] OP_IN  = 4'd10;
   localparam logic [3:0] OP_HLT = 4'd15;

   logic [2:0]        state_r;
   logic [3:0]        ir_op_r;
   logic [ADDR_W-1:0] ir_arg_r;
   logic              carry_r;
   logic              zero_r;
   logic [ADDR_W-1:0] ptr_r;
   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [DATA_W-1:0] rdata_r;

   logic [ADDR_W-1:0] raddr_s;
   logic [ADDR_W-1:0] waddr_s;
   logic [DATA_W-1:0] wdata_s;
   logic              we_s;
   logic [DATA_W:0]   sum_s;
   logic [DATA_W:0]   diff_s;
   logic [DATA_W-1:0] imm_s;

   // ALU results; the extra top bit is carry out (ADD) or borrow (SUB).
   always_comb begin
      sum_s  = {1'b0, acc} + {1'b0, rdata_r};
      diff_s = {1'b0, acc} - {1'b0, rdata_r};
      imm_s  = {{(DATA_W-ADDR_W){1'b0}}, ir_arg_r};
   end

   // Memory port steering: operand address in EXEC, pc otherwise; writes from STA or the loader.
   always_comb begin
      we_s    = 1'b0;
      waddr_s = ptr_r;
      wdata_s = pm_data;
      if (state_r == S_EXEC) begin
         raddr_s = ir_arg_r;
      end else begin
         raddr_s = pc;
      end
      if (!program_mode && (state_r == S_EXEC) && (ir_op_r == OP_STA)) begin
         we_s    = 1'b1;
         waddr_s = ir_arg_r;
         wdata_s = acc;
      end else if (program_mode && (state_r == S_PROG) && pm_data_we) begin
         we_s = 1'b1;
         if (pm_addr_we) begin
            waddr_s = pm_address;
         end else begin
            waddr_s = ptr_r;
         end
      end else begin
         we_s = 1'b0;
      end
   end

   // Word memory with synchronous read; contents survive reset.
   always_ff @(posedge sys_clk) begin
      if (we_s) begin
         mem_r[waddr_s] <= wdata_s;
      end
      rdata_r <= mem_r[raddr_s];
   end

   // Control sequencer, datapath registers and handshake outputs.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state_r   <= S_FETCH;
         pc        <= {ADDR_W{1'b0}};
         acc       <= {DATA_W{1'b0}};
         ir_op_r   <= 4'd0;
         ir_arg_r  <= {ADDR_W{1'b0}};
         carry_r   <= 1'b0;
         zero_r    <= 1'b0;
         ptr_r     <= {ADDR_W{1'b0}};
         out_data  <= {DATA_W{1'b0}};
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
         halted    <= 1'b0;
      end else if (program_mode) begin
         // Loader owns the core; any instruction in flight is abandoned.
         state_r   <= S_PROG;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
         halted    <= 1'b0;
         if (state_r == S_PROG) begin
            if (pm_data_we) begin
               ptr_r <= waddr_s + ADDR_W'(1'b1);
            end else if (pm_addr_we) begin
               ptr_r <= pm_address;
            end
         end
      end else begin
         case (state_r)
            S_FETCH: begin
               state_r <= S_DECODE;
            end
            S_DECODE: begin
               ir_op_r  <= rdata_r[DATA_W-1:DATA_W-4];
               ir_arg_r <= rdata_r[ADDR_W-1:0];
               pc       <= pc + ADDR_W'(1'b1);
               state_r  <= S_EXEC;
            end
            S_EXEC: begin
               state_r <= S_FETCH;
               case (ir_op_r)
                  OP_LDA, OP_ADD, OP_SUB: state_r <= S_MEM;
                  OP_LDI: begin
                     acc    <= imm_s;
                     zero_r <= (imm_s == {DATA_W{1'b0}});
                  end
                  OP_JMP: pc <= ir_arg_r;
                  OP_JC:  if (carry_r) pc <= ir_arg_r;
                  OP_JZ:  if (zero_r) pc <= ir_arg_r;
                  OP_OUT: begin
                     out_data  <= acc;
                     out_valid <= 1'b1;
                     state_r   <= S_OUTW;
                  end
                  OP_IN: begin
                     in_ready <= 1'b1;
                     state_r  <= S_INW;
                  end
                  OP_HLT: begin
                     halted  <= 1'b1;
                     state_r <= S_HALT;
                  end
                  default: state_r <= S_FETCH;
               endcase
            end
            S_MEM: begin
               state_r <= S_FETCH;
               case (ir_op_r)
                  OP_LDA: begin
                     acc    <= rdata_r;
                     zero_r <= (rdata_r == {DATA_W{1'b0}});
                  end
                  OP_ADD: begin
                     acc     <= sum_s[DATA_W-1:0];
                     carry_r <= sum_s[DATA_W];
                     zero_r  <= (sum_s[DATA_W-1:0] == {DATA_W{1'b0}});
                  end
                  OP_SUB: begin
                     acc     <= diff_s[DATA_W-1:0];
                     carry_r <= ~diff_s[DATA_W];
                     zero_r  <= (diff_s[DATA_W-1:0] == {DATA_W{1'b0}});
                  end
                  default: state_r <= S_FETCH;
               endcase
            end
            S_OUTW: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_r   <= S_FETCH;
               end
            end
            S_INW: begin
               if (in_valid) begin
                  acc      <= in_data;
                  zero_r   <= (in_data == {DATA_W{1'b0}});
                  in_ready <= 1'b0;
                  state_r  <= S_FETCH;
               end
            end
            S_HALT: begin
               state_r <= S_HALT;
            end
            S_PROG: begin
               // Leaving the loader restarts execution from a clean state.
               pc      <= {ADDR_W{1'b0}};
               acc     <= {DATA_W{1'b0}};
               carry_r <= 1'b0;
               zero_r  <= 1'b0;
               state_r <= S_FETCH;
            end
            default: state_r <= S_FETCH;
         endcase
      end
   end

endmodule

// File: doc/thistle_core_p.md
Name: thistle_core_p

Overview:
- Parametrised successor to the Thistle 8-bit bus CPU top level.
- Single-accumulator, multi-cycle core with data width and address depth set by parameters, and an internal word-addressed program/data memory.
- Program-mode loader auto-increments its address.
- Adds zero and carry flags with conditional jumps, and ready/valid handshaked I/O in place of the raw tristate port.
- Sits as the compute core under the board-level wrapper.

Parameters:
DATA_W, 8, data/instruction word width; must be >= ADDR_W+4.
ADDR_W, 4, memory address width; depth = 2**ADDR_W words.

Ports:
sys_clk  input  1  system clock; all state changes on rising edge.
rst  input  1  asynchronous, active-low reset.
program_mode  input  1  1 = core held, memory loadable via pm_* port.
pm_addr_we  input  1  load pm_address into the load pointer.
pm_address  input  ADDR_W  load pointer value.
pm_data_we  input  1  write pm_data at the load pointer, then increment the pointer.
pm_data  input  DATA_W  word to load.
in_data  input  DATA_W  input channel data.
in_valid  input  1  input data available.
in_ready  output  1  core accepting input (IN instruction waiting).
out_data  output  DATA_W  output channel data.
out_valid  output  1  out_data valid.
out_ready  input  1  sink accepts out_data.
halted  output  1  HLT executed.
pc  output  ADDR_W  current program counter (debug).
acc  output  DATA_W  accumulator (debug).

Behaviour:
- Reset (rst=0, async):
  - pc=0, acc=0, IR=0, carry=0, zero=0, load pointer=0.
  - out_data=0, out_valid=0, in_ready=0, halted=0, state=FETCH.
  - Memory contents are not reset.
- Instruction word format:
  - opcode = word[DATA_W-1:DATA_W-4].
  - operand = word[ADDR_W-1:0].
  - Bits in between are ignored.
- Memory read is synchronous: address presented in cycle N, data usable in cycle N+1.
- States and transitions:
  - FETCH: address=pc -> DECODE.
  - DECODE: IR<=mem rdata, pc<=pc+1 (wraps modulo 2**ADDR_W) -> EXEC.
  - EXEC: by opcode (list below).
  - MEM: completes LDA/ADD/SUB -> FETCH.
  - OUTW, INW: handshake waits (below).
  - HALT: terminal until reset or program_mode.
  - PROG: loader active (below).
- Opcodes executed in EXEC:
  - 0 NOP -> FETCH.
  - 1 LDA, 2 ADD, 3 SUB: address=operand -> MEM.
  - 4 STA: mem[operand]<=acc -> FETCH.
  - 5 LDI: acc<=zero-extended operand, zero updated -> FETCH.
  - 6 JMP: pc<=operand.
  - 7 JC: pc<=operand if carry=1.
  - 8 JZ: pc<=operand if zero=1.
  - 9 OUT -> OUTW.
  - 10 IN -> INW.
  - 15 HLT: halted<=1 -> HALT.
  - 11-14: treated as NOP.
- MEM (M = mem rdata):
  - LDA: acc<=M.
  - ADD: {carry,acc}<=acc+M.
  - SUB: acc<=acc-M; carry=1 iff no borrow (acc>=M unsigned).
  - zero<=(result==0) for LDA/ADD/SUB.
- Flags change only as above. JMP/JC/JZ/STA/OUT leave flags unchanged.
- Cycle counts: NOP/LDI/STA/JMP/JC/JZ/HLT = 3 cycles; LDA/ADD/SUB = 4 cycles; OUT/IN = 3 + wait cycles.
- OUTW:
  - On entry, out_data<=acc and out_valid<=1.
  - Hold both stable until the cycle out_ready=1; then out_valid<=0 -> FETCH.
  - If out_ready is already 1 on the first OUTW cycle, it completes that cycle (OUT = 4 cycles minimum).
  - out_data retains its value after the transfer.
- INW:
  - in_ready=1 while in INW.
  - On the cycle in_valid=1: acc<=in_data, zero updated, in_ready<=0 -> FETCH.
  - in_valid outside INW is ignored.
- PROG:
  - program_mode=1 in any state forces PROG on the next edge, aborting the instruction in flight.
  - Pending out_valid/in_ready drop to 0; halted clears.
  - In PROG: pm_addr_we loads the pointer. pm_data_we writes mem[pointer] and increments the pointer (wraps).
  - If both are asserted in the same cycle, the data is written at pm_address and the pointer becomes pm_address+1.
  - pm_* inputs are ignored when program_mode=0.
- Leaving PROG (program_mode 1->0): pc<=0, acc<=0, carry<=0, zero<=0 -> FETCH.
- HALT: all state frozen, no memory writes, outputs hold.
- Self-modifying code: a STA into the next instruction's address takes effect on that instruction's fetch.

Test Plan:
- Load mem[0..3]={LDA 14, ADD 15, OUT, HLT} (8'h1E,8'h2F,8'h90,8'hF0), mem[14]=8'd200, mem[15]=8'd100, out_ready=1, release program_mode -> out_data=8'd44, out_valid pulses 1 cycle, carry=1, halted=1 after 15 cycles.
- SUB equal: LDI 5, SUB addr(=5), JZ 6; mem[6]=OUT -> acc=0, zero=1, carry=1, jump taken, OUT executed.
- Output backpressure: OUT with out_ready=0 for 5 cycles -> out_valid stays 1, out_data stable, pc unchanged; completes the cycle out_ready rises.
- Input: IN with in_valid low 3 cycles then in_data=8'h00, in_valid=1 -> in_ready high 4 cycles, acc=0, zero=1.
- Loader: pm_addr_we with address 4'hE, then 3 pm_data_we writes -> mem[14],mem[15],mem[0] written (pointer wraps).
- Abort and reset: program_mode asserted during OUTW -> out_valid=0 next cycle. rst low mid-ADD -> all outputs at reset values immediately, memory preserved.
